tt_um_sel_seq: RTL and testbench

- Spine-side sequencer for one user tile; it drives the user module's side of the mux interface.
- Accepts select/deselect commands from the mux controller and sequences the user module's ena, clock enable and rst_n.
- Gates ui_in toward the module and uo_out back onto the spine.
- Guarantees the tile invariant at all times: ena=0 implies ui_in=0, rst_n=0, clock stopped.

---
 rtl/tt_um_sel_seq_if.sv | 11 +
 rtl/tt_um_sel_seq.sv | 161 ++++++++++++++++
 tb/tb_tt_um_sel_seq.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/tt_um_sel_seq_if.sv
// Select command bus between the mux controller (master) and a tile sequencer (slave).
interface tt_um_sel_seq_if #(
    parameter int ADDR_W = 10
);
    logic              sel_valid;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_ready;

    modport master (output sel_valid, output sel_addr, input  sel_ready);
    modport slave  (input  sel_valid, input  sel_addr, output sel_ready);
endinterface

// File: rtl/tt_um_sel_seq.sv
// Tile sequencer: brings the user module up and down through a clocked reset window.
// Optional macro TT_SEL_SYNC_EN adds 2-flop input synchronizers and strobe edge detection.
module tt_um_sel_seq #(
    parameter int ADDR_W     = 10,
    parameter int TILE_ADDR  = 0,
    parameter int RST_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    tt_um_sel_seq_if.slave        sel,
    input  logic                  spine_rst_n,
    input  logic [7:0]            spine_ui_in,
    output logic [7:0]            spine_uo_out,
    output logic                  um_ena,
    output logic                  um_clk_en,
    output logic                  um_rst_n,
    output logic [7:0]            um_ui_in,
    input  logic [7:0]            um_uo_out,
    output logic                  active
);
    localparam int CNT_W = $clog2(RST_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
    logic              cnt_done_s;
    logic              cmd_valid_s, cmd_is_this_s, rstn_in_s;
    logic [ADDR_W-1:0] cmd_addr_s;
    logic              ena_r, clk_en_r, rst_n_r, ready_r, active_r;
    logic              ena_nxt_s, clk_en_nxt_s, rst_n_nxt_s, ready_nxt_s, active_nxt_s;

`ifdef TT_SEL_SYNC_EN
    logic [1:0]        valid_sync_r;
    logic              valid_prev_r;
    logic [ADDR_W-1:0] addr_sync1_r, addr_sync2_r;
    logic [1:0]        rstn_sync_r;

    // Two-flop synchronizers plus a history flop for strobe edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_sync_r <= 2'b00;
            valid_prev_r <= 1'b0;
            addr_sync1_r <= {ADDR_W{1'b0}};
            addr_sync2_r <= {ADDR_W{1'b0}};
            rstn_sync_r  <= 2'b00;
        end else begin
            valid_sync_r <= {valid_sync_r[0], sel.sel_valid};
            valid_prev_r <= valid_sync_r[1];
            addr_sync1_r <= sel.sel_addr;
            addr_sync2_r <= addr_sync1_r;
            rstn_sync_r  <= {rstn_sync_r[0], spine_rst_n};
        end
    end

    assign cmd_valid_s = valid_sync_r[1] & ~valid_prev_r;
    assign cmd_addr_s  = addr_sync2_r;
    assign rstn_in_s   = rstn_sync_r[1];
`else
    assign cmd_valid_s = sel.sel_valid;
    assign cmd_addr_s  = sel.sel_addr;
    assign rstn_in_s   = spine_rst_n;
`endif

    assign cmd_is_this_s = (cmd_addr_s == ADDR_W'(TILE_ADDR));
    assign cnt_done_s    = (cnt_r == CNT_W'(RST_CYCLES - 1));

    // Next state; commands outside IDLE/RUN fall through and are dropped
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:  if (cmd_valid_s && cmd_is_this_s)  state_nxt_s = ST_START; else state_nxt_s = ST_IDLE;
            ST_START: if (cnt_done_s)                    state_nxt_s = ST_RUN;   else state_nxt_s = ST_START;
            ST_RUN:   if (cmd_valid_s && !cmd_is_this_s) state_nxt_s = ST_STOP;  else state_nxt_s = ST_RUN;
            ST_STOP:  if (cnt_done_s)                    state_nxt_s = ST_IDLE;  else state_nxt_s = ST_STOP;
            default:                                     state_nxt_s = ST_IDLE;
        endcase
    end

    // Counter and output values decoded from the state being entered, so outputs stay registered
    always_comb begin
        ena_nxt_s    = 1'b0;
        clk_en_nxt_s = 1'b0;
        rst_n_nxt_s  = 1'b0;
        ready_nxt_s  = 1'b1;
        active_nxt_s = 1'b0;
        if (state_nxt_s != state_r) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else if ((state_r == ST_START || state_r == ST_STOP) && !cnt_done_s) begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
        case (state_nxt_s)
            ST_IDLE: begin
                ready_nxt_s  = 1'b1;
            end
            ST_START, ST_STOP: begin
                ena_nxt_s    = 1'b1;
                clk_en_nxt_s = 1'b1;
                ready_nxt_s  = 1'b0;
            end
            ST_RUN: begin
                ena_nxt_s    = 1'b1;
                clk_en_nxt_s = 1'b1;
                rst_n_nxt_s  = rstn_in_s;
                active_nxt_s = 1'b1;
            end
            default: begin
                ready_nxt_s  = 1'b1;
            end
        endcase
    end

    // State, counter and output registers; reset lands directly on IDLE values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            ena_r    <= 1'b0;
            clk_en_r <= 1'b0;
            rst_n_r  <= 1'b0;
            ready_r  <= 1'b1;
            active_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            ena_r    <= ena_nxt_s;
            clk_en_r <= clk_en_nxt_s;
            rst_n_r  <= rst_n_nxt_s;
            ready_r  <= ready_nxt_s;
            active_r <= active_nxt_s;
        end
    end

    assign um_ena        = ena_r;
    assign um_clk_en     = clk_en_r;
    assign um_rst_n      = rst_n_r;
    assign active        = active_r;
    assign sel.sel_ready = ready_r;
    assign um_ui_in      = spine_ui_in & {8{ena_r}};
    assign spine_uo_out  = um_uo_out & {8{ena_r}};
endmodule

// Tile invariant checker: a disabled tile sees no inputs, no clock and held reset.
module tt_um_sel_seq_chk (
    input logic       clk,
    input logic       um_ena,
    input logic       um_clk_en,
    input logic       um_rst_n,
    input logic [7:0] um_ui_in,
    input logic [7:0] spine_uo_out
);
    a_tile_invariant: assert property (@(negedge clk)
        !um_ena |-> (um_ui_in == 8'h00 && um_rst_n == 1'b0 && um_clk_en == 1'b0 && spine_uo_out == 8'h00));
endmodule

// File: tb/tb_tt_um_sel_seq.sv
// Scoreboard bench for tt_um_sel_seq: reference model pushes expectations, negedge monitor checks.
module tb_tt_um_sel_seq;
    localparam int ADDR_W     = 10;
    localparam int TILE_ADDR  = 3;
    localparam int RST_CYCLES = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       spine_rst_n = 1'b1;
    logic [7:0] spine_ui_in = 8'h00;
    logic [7:0] spine_uo_out;
    logic       um_ena, um_clk_en, um_rst_n, active;
    logic [7:0] um_ui_in;
    logic [7:0] um_uo_out = 8'h00;

    tt_um_sel_seq_if #(.ADDR_W(ADDR_W)) bus ();

    tt_um_sel_seq #(.ADDR_W(ADDR_W), .TILE_ADDR(TILE_ADDR), .RST_CYCLES(RST_CYCLES)) dut (
        .clk(clk), .rst(rst), .sel(bus.slave),
        .spine_rst_n(spine_rst_n), .spine_ui_in(spine_ui_in), .spine_uo_out(spine_uo_out),
        .um_ena(um_ena), .um_clk_en(um_clk_en), .um_rst_n(um_rst_n),
        .um_ui_in(um_ui_in), .um_uo_out(um_uo_out), .active(active)
    );

    tt_um_sel_seq_chk u_chk (
        .clk(clk), .um_ena(um_ena), .um_clk_en(um_clk_en), .um_rst_n(um_rst_n),
        .um_ui_in(um_ui_in), .spine_uo_out(spine_uo_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [20:0] exp_q[$];

    // Reference model: tile power phase plus cycles left in the current reset window
    int   phase = 0;   // 0 off, 1 powering up, 2 running, 3 powering down
    int   left  = 0;
    logic m_rstn = 1'b0;

    task automatic model_edge();
        if (rst) begin
            phase = 0; left = 0; m_rstn = 1'b0;
        end else begin
            if (phase == 0) begin
                if (bus.sel_valid && bus.sel_addr == ADDR_W'(TILE_ADDR)) begin phase = 1; left = RST_CYCLES; end
            end else if (phase == 1) begin
                left = left - 1;
                if (left == 0) phase = 2;
            end else if (phase == 2) begin
                if (bus.sel_valid && bus.sel_addr != ADDR_W'(TILE_ADDR)) begin phase = 3; left = RST_CYCLES; end
            end else begin
                left = left - 1;
                if (left == 0) phase = 0;
            end
            m_rstn = (phase == 2) ? spine_rst_n : 1'b0;
        end
    endtask

    task automatic push_expected();
        logic on;
        on = (phase != 0);
        exp_q.push_back({on, on, m_rstn, (phase == 0 || phase == 2), (phase == 2),
                         on ? spine_ui_in : 8'h00, on ? um_uo_out : 8'h00});
    endtask

    task automatic step(input logic v, input logic [ADDR_W-1:0] a, input logic srn,
                        input logic r, input logic [7:0] ui, input logic [7:0] uo);
        @(posedge clk);
        model_edge();
        #2;
        bus.sel_valid = v; bus.sel_addr = a; spine_rst_n = srn;
        spine_ui_in = ui; um_uo_out = uo; rst = r;
        if (r) begin phase = 0; left = 0; m_rstn = 1'b0; end
        push_expected();
    endtask

    task automatic idle(input int n, input logic [7:0] uo);
        for (int i = 0; i < n; i++) step(1'b0, ADDR_W'(TILE_ADDR), 1'b1, 1'b0, 8'hA5, uo);
    endtask

    // Monitor: compare every presented output vector against the oldest expectation
    initial begin
        logic [20:0] got, want;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                got  = {um_ena, um_clk_en, um_rst_n, bus.sel_ready, active, um_ui_in, spine_uo_out};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL outputs t=%0t {ena,clk_en,rst_n,ready,active,ui,uo} got=%b_%h_%h want=%b_%h_%h",
                             $time, got[20:16], got[15:8], got[7:0], want[20:16], want[15:8], want[7:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ADDR_W-1:0] desel, a;
        logic v, srn, r;
        desel = ADDR_W'(TILE_ADDR + 1);
        bus.sel_valid = 1'b0;
        bus.sel_addr  = {ADDR_W{1'b0}};
        // Reset held, then released with inputs active but tile off
        for (int i = 0; i < 3; i++) step(1'b0, {ADDR_W{1'b0}}, 1'b1, 1'b1, 8'hA5, 8'h3C);
        idle(3, 8'h3C);
        // Select, bring-up window, run with outputs passed through
        step(1'b1, ADDR_W'(TILE_ADDR), 1'b1, 1'b0, 8'hA5, 8'h3C);
        idle(7, 8'h3C);
        // Deselect and shutdown window
        step(1'b1, desel, 1'b1, 1'b0, 8'hA5, 8'h3C);
        idle(7, 8'h3C);
        // Deselect issued during START is dropped
        step(1'b1, ADDR_W'(TILE_ADDR), 1'b1, 1'b0, 8'h5A, 8'hC3);
        idle(1, 8'hC3);
        step(1'b1, desel, 1'b1, 1'b0, 8'h5A, 8'hC3);
        idle(6, 8'hC3);
        // Reset asserted during STOP at counter 2
        step(1'b1, desel, 1'b1, 1'b0, 8'h11, 8'h22);
        idle(2, 8'h22);
        step(1'b0, desel, 1'b1, 1'b1, 8'h11, 8'h22);
        step(1'b0, desel, 1'b1, 1'b1, 8'h11, 8'h22);
        idle(3, 8'h22);
        // spine_rst_n low pulse while running
        step(1'b1, ADDR_W'(TILE_ADDR), 1'b1, 1'b0, 8'h77, 8'h88);
        idle(6, 8'h88);
        for (int i = 0; i < 3; i++) step(1'b0, desel, 1'b0, 1'b0, 8'h77, 8'h88);
        idle(4, 8'h88);
        // Randomized traffic including held strobes, stray addresses and rare resets
        for (int i = 0; i < 500; i++) begin
            v   = ($urandom_range(3) == 0);
            a   = ($urandom_range(1) == 0) ? ADDR_W'(TILE_ADDR) : ADDR_W'($urandom);
            srn = ($urandom_range(7) != 0);
            r   = ($urandom_range(63) == 0);
            step(v, a, srn, r, 8'($urandom), 8'($urandom));
        end
        idle(2, 8'h00);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
